// File: rtl/sparc_fetch_unit.sv
// sparc_fetch_unit: PC/nPC fetch stage for a 512-byte instruction memory.
// Captures the fetched big-endian word into the IF/ID register.
module sparc_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [8:0]  branch_target,
  input  logic        annul,
  input  logic [31:0] instr_in,
  output logic [8:0]  pc,
  output logic [8:0]  npc,
  output logic [31:0] if_id_instr,
  output logic [8:0]  if_id_pc,
  output logic        if_id_valid
);

  logic [8:0]  r_pc;
  logic [8:0]  r_npc;
  logic [31:0] r_instr;
  logic [8:0]  r_if_pc;
  logic        r_valid;
  logic [8:0]  w_tgt;
  logic [8:0]  w_next_pc;

  // Target is forced word-aligned; the delay slot is whatever nPC held.
  assign w_tgt     = {branch_target[8:2], 2'b00};
  assign w_next_pc = branch_taken ? w_tgt : r_npc;

  // PC/nPC advance and IF/ID capture; annul turns the capture into a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= 9'd0;
      r_npc   <= 9'd4;
      r_instr <= 32'h0;
      r_if_pc <= 9'd0;
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_pc    <= w_next_pc;
      r_npc   <= w_next_pc + 9'd4;
      r_if_pc <= r_pc;
      if (annul) begin
        r_instr <= 32'h0;
        r_valid <= 1'b0;
      end else begin
        r_instr <= instr_in;
        r_valid <= 1'b1;
      end
    end
  end

  assign pc          = r_pc;
  assign npc         = r_npc;
  assign if_id_instr = r_instr;
  assign if_id_pc    = r_if_pc;
  assign if_id_valid = r_valid;

endmodule

// File: tb/tb_sparc_fetch_unit.sv
// tb_sparc_fetch_unit: directed checks of sequencing, branch,
// annul, stall, address wrap and reset for sparc_fetch_unit.
module tb_sparc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [8:0]  branch_target;
  logic        annul;
  logic [31:0] instr_in;
  logic [8:0]  pc;
  logic [8:0]  npc;
  logic [31:0] if_id_instr;
  logic [8:0]  if_id_pc;
  logic        if_id_valid;

  logic [7:0]  mem [0:511];
  int          n_chk = 0;
  int          n_pass = 0;

  sparc_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .annul         (annul),
    .instr_in      (instr_in),
    .pc            (pc),
    .npc           (npc),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid)
  );

  always #5 clk = ~clk;

  // Big-endian combinational instruction memory.
  always_comb begin
    instr_in = {mem[pc], mem[pc + 9'd1],
                mem[pc + 9'd2], mem[pc + 9'd3]};
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic chk_ifid(input string tag,
                          input logic [8:0] epc,
                          input logic [31:0] ei,
                          input logic ev);
    chk({tag, "_pc"}, {23'd0, if_id_pc}, {23'd0, epc});
    chk({tag, "_in"}, if_id_instr, ei);
    chk({tag, "_v"}, {31'd0, if_id_valid}, {31'd0, ev});
  endtask

  initial begin
    // Byte i holds i[7:0]^8'h5A, so word@a = hand-computed constants below.
    for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h5A;
    reset = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 9'd0;
    annul = 1'b0;

    step();
    chk("rst_pc", {23'd0, pc}, 32'd0);
    chk("rst_npc", {23'd0, npc}, 32'd4);
    chk_ifid("rst", 9'd0, 32'h0, 1'b0);
    reset = 1'b0;

    step(); chk_ifid("seq0", 9'd0,  32'h5A5B5859, 1'b1);
    step(); chk_ifid("seq1", 9'd4,  32'h5E5F5C5D, 1'b1);
    step(); chk_ifid("seq2", 9'd8,  32'h52535051, 1'b1);
    step(); chk_ifid("seq3", 9'd12, 32'h56575455, 1'b1);
    chk("seq_pc", {23'd0, pc}, 32'h10);

    // Taken branch at pc=8, target bits [1:0] discarded.
    do_reset();
    step(); step();
    chk("pre_br_pc", {23'd0, pc}, 32'd8);
    branch_taken = 1'b1; branch_target = 9'h041;
    step();
    branch_taken = 1'b0;
    chk_ifid("dslot", 9'd8, 32'h52535051, 1'b1);
    chk("br_pc", {23'd0, pc}, 32'h40);
    chk("br_npc", {23'd0, npc}, 32'h44);
    step();
    chk_ifid("tgt", 9'h40, 32'h1A1B1819, 1'b1);
    chk("tgt_pc", {23'd0, pc}, 32'h44);

    // Same branch with the delay slot annulled.
    do_reset();
    step(); step();
    branch_taken = 1'b1; annul = 1'b1; branch_target = 9'h041;
    step();
    branch_taken = 1'b0; annul = 1'b0;
    chk_ifid("annul", 9'd8, 32'h0, 1'b0);
    chk("an_pc", {23'd0, pc}, 32'h40);
    step();
    chk_ifid("an_tgt", 9'h40, 32'h1A1B1819, 1'b1);

    // Stall at pc=0x10 with a branch held pending.
    do_reset();
    repeat (4) step();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 9'h080;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("st_pc", {23'd0, pc}, 32'h10);
      chk("st_npc", {23'd0, npc}, 32'h14);
      chk_ifid("st", 9'd12, 32'h56575455, 1'b1);
    end
    stall = 1'b0;
    step();
    branch_taken = 1'b0;
    chk("rel_pc", {23'd0, pc}, 32'h80);
    chk("rel_npc", {23'd0, npc}, 32'h84);
    chk_ifid("rel", 9'h10, 32'h4A4B4849, 1'b1);

    // Address wrap from 0x1FC.
    branch_taken = 1'b1; branch_target = 9'h1FF;
    step();
    branch_taken = 1'b0;
    chk("wr_pc", {23'd0, pc}, 32'h1FC);
    chk("wr_npc", {23'd0, npc}, 32'h0);
    step();
    chk("wr_pc2", {23'd0, pc}, 32'h0);
    chk_ifid("wr0", 9'h1FC, 32'hA6A7A4A5, 1'b1);
    step();
    chk_ifid("wr1", 9'h0, 32'h5A5B5859, 1'b1);

    // Reset during a stall with a branch asserted.
    do_reset();
    repeat (8) step();
    chk("pre_rs_pc", {23'd0, pc}, 32'h20);
    stall = 1'b1;
    step();
    reset = 1'b1; branch_taken = 1'b1; branch_target = 9'h100;
    step();
    chk("rs_pc", {23'd0, pc}, 32'd0);
    chk("rs_npc", {23'd0, npc}, 32'd4);
    chk_ifid("rs", 9'd0, 32'h0, 1'b0);
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    step();
    chk_ifid("rs_w0", 9'd0, 32'h5A5B5859, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
